// File: rtl/neighbor_window_gen_if.sv
// rtl/neighbor_window_gen_if.sv - sample stream, window outputs and status of neighbor_window_gen
interface neighbor_window_gen_if #(
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_ready;
    logic                     out_valid;
    logic                     out_last;
    logic [3:0]               count;
    logic signed [DATA_W-1:0] data0_o;
    logic signed [DATA_W-1:0] dataP1_o;
    logic signed [DATA_W-1:0] dataP2_o;
    logic signed [DATA_W-1:0] dataP3_o;
    logic signed [DATA_W-1:0] dataM1_o;
    logic signed [DATA_W-1:0] dataM2_o;
    logic signed [DATA_W-1:0] dataM3_o;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_last, count, busy,
        input  data0_o, dataP1_o, dataP2_o, dataP3_o, dataM1_o, dataM2_o, dataM3_o
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_last, count, busy,
        output data0_o, dataP1_o, dataP2_o, dataP3_o, dataM1_o, dataM2_o, dataM3_o
    );
endinterface

// File: rtl/neighbor_window_gen.sv
// rtl/neighbor_window_gen.sv - buffers a 16-sample frame and emits +/-3 neighbour windows
// Optional NEIGHBOR_WINDOW_PINGPONG_EN: two banks so loading overlaps window emission.
module neighbor_window_gen #(
    parameter int DATA_W  = 32,
    parameter int FRAME_N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    neighbor_window_gen_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD     = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;
    localparam logic [3:0] LAST_IDX = 4'(FRAME_N - 1);

    logic [1:0]        state;
    logic [3:0]        wr_ptr;
    logic [3:0]        rd_idx;
    logic [DATA_W-1:0] rd_frame [FRAME_N];
    logic [DATA_W-1:0] win      [7];
    logic [DATA_W-1:0] win_q    [7];
    logic [3:0]        count_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              in_ready;
    logic              wr_fire;
    logic              wr_done;
    logic              rd_fire;
    logic              rd_done;
    logic              load_win;
    logic              start_run;
    logic              chain_run;

`ifdef NEIGHBOR_WINDOW_PINGPONG_EN
    logic [DATA_W-1:0] mem [2][FRAME_N];
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;

    // When nothing is being read, the read and write banks coincide.
    assign in_ready  = !rst && !full[wr_bank];
    assign start_run = full[rd_bank] || (wr_done && (wr_bank == rd_bank));
    assign chain_run = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));
    assign bus.busy  = (state != IDLE) || (wr_ptr != '0) || (full != '0);

    always_comb begin
        for (int i = 0; i < FRAME_N; i++) rd_frame[i] = mem[rd_bank][i];
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
        end else begin
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end
`else
    logic [DATA_W-1:0] mem [FRAME_N];

    assign in_ready  = !rst && (state != RUN);
    assign start_run = wr_done;
    assign chain_run = 1'b0;
    assign bus.busy  = (state != IDLE);

    always_comb begin
        for (int i = 0; i < FRAME_N; i++) rd_frame[i] = mem[i];
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= bus.in_data;
    end
`endif

    // Tap k covers offset k-3; positions outside 0..15 land on 16..18 or 29..31 and read as zero.
    for (genvar k = 0; k < 7; k++) begin : g_tap
        logic [4:0] pos;
        assign pos    = {1'b0, rd_idx} + 5'(k) - 5'd3;
        assign win[k] = pos[4] ? '0 : rd_frame[pos[3:0]];
    end

    assign wr_fire  = bus.in_valid && in_ready;
    assign wr_done  = wr_fire && (wr_ptr == LAST_IDX);
    assign rd_fire  = out_valid_q && bus.out_ready;
    assign rd_done  = rd_fire && out_last_q;
    assign load_win = (state == RUN) && (!out_valid_q || (bus.out_ready && !out_last_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < 7; k++) win_q[k] <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 4'd1;

            case (state)
                IDLE, LOAD: begin
                    if (start_run) begin
                        state  <= RUN;
                        rd_idx <= '0;
                    end else if (wr_fire) begin
                        state <= LOAD;
                    end
                end
                RUN: begin
                    if (rd_done) begin
                        rd_idx <= '0;
                        if (chain_run)                      state <= RUN;
                        else if (wr_fire || wr_ptr != '0)   state <= LOAD;
                        else                                state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // rd_idx points at the next window to load, so count lags it by one.
            if (load_win) begin
                count_q     <= rd_idx;
                out_last_q  <= (rd_idx == LAST_IDX);
                out_valid_q <= 1'b1;
                rd_idx      <= rd_idx + 4'd1;
                for (int k = 0; k < 7; k++) win_q[k] <= win[k];
            end else if (rd_done) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.count     = count_q;
    assign bus.dataM3_o  = win_q[0];
    assign bus.dataM2_o  = win_q[1];
    assign bus.dataM1_o  = win_q[2];
    assign bus.data0_o   = win_q[3];
    assign bus.dataP1_o  = win_q[4];
    assign bus.dataP2_o  = win_q[5];
    assign bus.dataP3_o  = win_q[6];
endmodule

// File: tb/tb_neighbor_window_gen.sv
// tb/tb_neighbor_window_gen.sv - randomized bench for neighbor_window_gen against a frame-queue model
module tb_neighbor_window_gen;
    localparam int DATA_W = 32;
`ifdef NEIGHBOR_WINDOW_PINGPONG_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif
    localparam int M_STREAM = 0;
    localparam int M_BP     = 1;
    localparam int M_SPARSE = 2;
    localparam int M_RAND   = 3;
    localparam int M_IDLE   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    neighbor_window_gen_if #(.DATA_W(DATA_W)) bus ();

    neighbor_window_gen #(.DATA_W(DATA_W), .FRAME_N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          cyc       = 0;
    int          mode      = M_IDLE;
    int          next_val  = 0;
    int          acc_total = 0;
    // Model: pend holds every accepted sample not yet fully windowed; done_q the cycle each frame completed.
    logic [31:0] pend   [$];
    int          done_q [$];
    int          cur_n     = 0;
    int          pos       = 0;
    int          last_acc  = -100;
    bit          after_rst = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        case (mode)
            M_STREAM: begin bus.in_valid = 1'b1; bus.out_ready = 1'b1; end
            M_BP: begin
                bus.in_valid  = 1'b1;
                bus.out_ready = ((cyc % 4) == 1 || (cyc % 4) == 2) ? 1'b0 : 1'b1;
            end
            M_SPARSE: begin bus.in_valid = ((cyc % 3) == 0); bus.out_ready = 1'b1; end
            M_RAND: begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            default: begin bus.in_valid = 1'b0; bus.out_ready = 1'b1; end
        endcase
        bus.in_data = DATA_W'(next_val);
    endtask

    task automatic step();
        bit          exp_rdy;
        bit          exp_v;
        bit          in_acc;
        bit          out_acc;
        int          rdy_at;
        int          idx;
        logic [31:0] in_val;
        logic [31:0] exp_d;
        logic [31:0] got_t [7];
        string       tn    [7];
        tn = '{"dM3", "dM2", "dM1", "d0", "dP1", "dP2", "dP3"};
        #1;
        exp_rdy = !rst && (done_q.size() < BANKS);
        exp_v   = 1'b0;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (!rst) begin
            if (after_rst) begin
                check("rst_count", 32'(bus.count), 32'd0);
                check("rst_last", 32'(bus.out_last), 32'd0);
                check("rst_d0", bus.data0_o, 32'd0);
                check("rst_dP1", bus.dataP1_o, 32'd0);
                check("rst_dM1", bus.dataM1_o, 32'd0);
            end
            if (done_q.size() > 0) begin
                rdy_at = ((done_q[0] > last_acc) ? done_q[0] : last_acc) + 2;
                exp_v  = (pos > 0) || (cyc >= rdy_at);
            end
            check("out_valid", 32'(bus.out_valid), 32'(exp_v));
            if (bus.out_valid && exp_v) begin
                got_t = '{bus.dataM3_o, bus.dataM2_o, bus.dataM1_o, bus.data0_o,
                          bus.dataP1_o, bus.dataP2_o, bus.dataP3_o};
                check("count", 32'(bus.count), 32'(pos));
                check("out_last", 32'(bus.out_last), 32'(pos == 15));
                for (int k = 0; k < 7; k++) begin
                    idx   = pos + k - 3;
                    exp_d = (idx >= 0 && idx < 16) ? pend[idx] : 32'd0;
                    check(tn[k], got_t[k], exp_d);
                end
            end
            check("busy", 32'(bus.busy), 32'(done_q.size() > 0 || cur_n > 0));
        end
        in_acc    = bus.in_valid && exp_rdy;
        out_acc   = bus.out_valid && bus.out_ready && exp_v;
        in_val    = bus.in_data;
        after_rst = rst;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            done_q.delete();
            cur_n    = 0;
            pos      = 0;
            last_acc = -100;
        end else begin
            if (in_acc) begin
                pend.push_back(in_val);
                acc_total++;
                cur_n++;
                if (cur_n == 16) begin
                    cur_n = 0;
                    done_q.push_back(cyc);
                end
                next_val = (mode == M_RAND) ? int'($urandom) : next_val + 1;
            end
            if (out_acc) begin
                pos++;
                if (pos == 16) begin
                    for (int i = 0; i < 16; i++) void'(pend.pop_front());
                    void'(done_q.pop_front());
                    pos      = 0;
                    last_acc = cyc;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        mode = M_IDLE;
        drive();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        next_val = 1;
        mode     = M_STREAM;
        repeat (75) begin drive(); step(); end

        do_reset();
        next_val = -5;
        mode     = M_SPARSE;
        repeat (80) begin drive(); step(); end

        do_reset();
        next_val  = 0;
        acc_total = 0;
        mode      = M_STREAM;
        for (int i = 0; i < 40 && acc_total < 9; i++) begin drive(); step(); end
        check("pre_reset_samples", 32'(acc_total), 32'd9);
        do_reset();
        next_val = 100;
        mode     = M_STREAM;
        repeat (45) begin drive(); step(); end

        do_reset();
        next_val = 1;
        mode     = M_BP;
        repeat (120) begin drive(); step(); end

        next_val = int'($urandom);
        mode     = M_RAND;
        repeat (600) begin
            rst = ($urandom_range(0, 249) == 0);
            drive();
            step();
        end
        rst = 1'b0;

        mode = M_IDLE;
        repeat (60) begin drive(); step(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
